carrd_vrf: RTL and testbench

- Vector register file: the receiving end of the writeback stage's write interface (v_reg_wr_en / x_reg_wr_en / el_wr_en / reg_wr_addr / four 128-bit data lanes).
- Holds 32 x 512-bit vector registers, split into 4 x 128-bit lane slices.
- Provides two synchronous read ports to the vector lanes.
- Returns scalar (x) results to the host core through a one-entry valid/ready buffer.
- Clears all storage itself after reset with an init sweep.

---
 rtl/carrd_pkg.sv | 16 +
 rtl/carrd_vrf_xbuf.sv | 35 +++
 rtl/carrd_vrf.sv | 123 ++++++++++++
 tb/tb_carrd_vrf.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/carrd_pkg.sv
// Shared constants and types for the carrd vector register file.
package carrd_pkg;

  localparam int unsigned CARRD_NUM_REGS  = 32;
  localparam int unsigned CARRD_LANE_W    = 128;
  localparam int unsigned CARRD_NUM_LANES = 4;
  localparam int unsigned CARRD_ELEM_W    = 32;

  typedef logic [511:0] vreg_t;

  typedef enum logic {
    VRF_INIT = 1'b0,
    VRF_RUN  = 1'b1
  } vrf_state_t;

endpackage

// File: rtl/carrd_vrf_xbuf.sv
// One-entry valid/ready buffer returning scalar results to the host core.
module carrd_vrf_xbuf #(
  parameter int unsigned ELEM_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ELEM_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [ELEM_W-1:0] data,
  output logic              drop
);

  logic slot_free;
  logic accept;

  // A slot being drained this cycle can take a new value with no bubble.
  assign slot_free = !valid || ready;
  assign accept    = valid && ready;
  assign drop      = load && !slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && slot_free) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/carrd_vrf.sv
// Vector register file: 32 x 512-bit registers, two read ports, scalar return
// buffer, and a post-reset clearing sweep.
module carrd_vrf
  import carrd_pkg::*;
#(
  parameter int unsigned NUM_REGS  = CARRD_NUM_REGS,
  parameter int unsigned LANE_W    = CARRD_LANE_W,
  parameter int unsigned NUM_LANES = CARRD_NUM_LANES,
  parameter int unsigned ELEM_W    = CARRD_ELEM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        v_reg_wr_en,
  input  logic                        x_reg_wr_en,
  input  logic                        el_wr_en,
  input  logic [4:0]                  reg_wr_addr,
  input  logic [LANE_W-1:0]           reg_wr_data,
  input  logic [LANE_W-1:0]           reg_wr_data_2,
  input  logic [LANE_W-1:0]           reg_wr_data_3,
  input  logic [LANE_W-1:0]           reg_wr_data_4,
  input  logic                        rd_en,
  input  logic [4:0]                  rd_addr_a,
  input  logic [4:0]                  rd_addr_b,
  output logic [LANE_W*NUM_LANES-1:0] rd_data_a,
  output logic [LANE_W*NUM_LANES-1:0] rd_data_b,
  output logic                        x_wb_valid,
  output logic [ELEM_W-1:0]           x_wb_data,
  input  logic                        x_wb_ready,
  output logic                        init_done,
  output logic                        err_drop
);

  localparam int unsigned REG_W = LANE_W * NUM_LANES;
  localparam logic [4:0]  LAST  = 5'(NUM_REGS - 1);

  logic [REG_W-1:0] mem [NUM_REGS];
  vrf_state_t       state;
  logic [4:0]       cnt;

  logic             run;
  logic             any_strobe;
  logic             vec_wr;
  logic             x_load;
  logic             x_drop;
  logic [REG_W-1:0] wr_val;

  assign run        = (state == VRF_RUN);
  assign any_strobe = v_reg_wr_en || x_reg_wr_en || el_wr_en;
  assign vec_wr     = run && (v_reg_wr_en || el_wr_en);
  assign x_load     = run && x_reg_wr_en;

  // Full write wins over element write; element write merges into old contents.
  always_comb begin
    wr_val = '0;
    if (v_reg_wr_en) begin
      wr_val = {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data};
    end else begin
      wr_val = {mem[reg_wr_addr][REG_W-1:ELEM_W], reg_wr_data[ELEM_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= VRF_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == VRF_INIT) begin
      cnt <= cnt + 5'd1;
      if (cnt == LAST) begin
        state     <= VRF_RUN;
        init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[cnt] <= '0;
      end else if (vec_wr) begin
        mem[reg_wr_addr] <= wr_val;
      end
    end
  end

  // Same-address write in the same cycle is forwarded to the read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_en) begin
      if (!run) begin
        rd_data_a <= '0;
        rd_data_b <= '0;
      end else begin
        rd_data_a <= (vec_wr && (rd_addr_a == reg_wr_addr)) ? wr_val : mem[rd_addr_a];
        rd_data_b <= (vec_wr && (rd_addr_b == reg_wr_addr)) ? wr_val : mem[rd_addr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_drop <= 1'b0;
    end else if ((!run && any_strobe) || x_drop) begin
      err_drop <= 1'b1;
    end
  end

  carrd_vrf_xbuf #(
    .ELEM_W(ELEM_W)
  ) u_xbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (x_load),
    .load_data(reg_wr_data[ELEM_W-1:0]),
    .ready    (x_wb_ready),
    .valid    (x_wb_valid),
    .data     (x_wb_data),
    .drop     (x_drop)
  );

endmodule

// File: tb/tb_carrd_vrf.sv
// Self-checking bench for carrd_vrf: directed steps plus random traffic
// compared each cycle against a register-array reference model.
module tb_carrd_vrf;

  logic         clk;
  logic         rst;
  logic         v_reg_wr_en;
  logic         x_reg_wr_en;
  logic         el_wr_en;
  logic [4:0]   reg_wr_addr;
  logic [127:0] reg_wr_data;
  logic [127:0] reg_wr_data_2;
  logic [127:0] reg_wr_data_3;
  logic [127:0] reg_wr_data_4;
  logic         rd_en;
  logic [4:0]   rd_addr_a;
  logic [4:0]   rd_addr_b;
  logic [511:0] rd_data_a;
  logic [511:0] rd_data_b;
  logic         x_wb_valid;
  logic [31:0]  x_wb_data;
  logic         x_wb_ready;
  logic         init_done;
  logic         err_drop;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [511:0] m_mem [32];
  logic [511:0] m_a, m_b;
  logic         m_run, m_xv, m_err, m_idone;
  logic [31:0]  m_xd;
  int           m_sweep;

  carrd_vrf #(
    .NUM_REGS (32),
    .LANE_W   (128),
    .NUM_LANES(4),
    .ELEM_W   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .v_reg_wr_en  (v_reg_wr_en),
    .x_reg_wr_en  (x_reg_wr_en),
    .el_wr_en     (el_wr_en),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_data_2(reg_wr_data_2),
    .reg_wr_data_3(reg_wr_data_3),
    .reg_wr_data_4(reg_wr_data_4),
    .rd_en        (rd_en),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .x_wb_valid   (x_wb_valid),
    .x_wb_data    (x_wb_data),
    .x_wb_ready   (x_wb_ready),
    .init_done    (init_done),
    .err_drop     (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_step();
    logic [511:0] nv;
    if (rst) begin
      m_run = 0; m_sweep = 0; m_a = '0; m_b = '0;
      m_xv = 0; m_xd = '0; m_err = 0; m_idone = 0;
    end else if (!m_run) begin
      if (v_reg_wr_en || x_reg_wr_en || el_wr_en) m_err = 1;
      if (rd_en) begin m_a = '0; m_b = '0; end
      m_mem[m_sweep] = '0;
      m_sweep++;
      if (m_sweep == 32) begin m_run = 1; m_idone = 1; end
    end else begin
      nv = m_mem[reg_wr_addr];
      if (v_reg_wr_en) nv = {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data};
      else if (el_wr_en) nv[31:0] = reg_wr_data[31:0];
      if (v_reg_wr_en || el_wr_en) m_mem[reg_wr_addr] = nv;
      if (rd_en) begin
        m_a = m_mem[rd_addr_a];
        m_b = m_mem[rd_addr_b];
      end
      if (x_reg_wr_en) begin
        if (m_xv && !x_wb_ready) m_err = 1;
        else begin m_xv = 1; m_xd = reg_wr_data[31:0]; end
      end else if (m_xv && x_wb_ready) begin
        m_xv = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rd_data_a", rd_data_a, m_a);
    check("rd_data_b", rd_data_b, m_b);
    check("x_wb_valid", x_wb_valid, m_xv);
    check("x_wb_data", x_wb_data, m_xd);
    check("init_done", init_done, m_idone);
    check("err_drop", err_drop, m_err);
  endtask

  task automatic idle();
    v_reg_wr_en = 0; x_reg_wr_en = 0; el_wr_en = 0;
    rd_en = 0; x_wb_ready = 0;
  endtask

  initial begin
    m_run = 0; m_sweep = 0;
    rst = 1; idle();
    reg_wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    reg_wr_data = '0; reg_wr_data_2 = '0; reg_wr_data_3 = '0; reg_wr_data_4 = '0;

    tick();
    check("reset_rd_a", rd_data_a, '0);
    check("reset_valid", x_wb_valid, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    rst = 0;

    for (int i = 0; i < 32; i++) begin
      idle();
      v_reg_wr_en = (i == 5);
      rd_en = 1; rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      tick();
      check("init_done_timing", init_done, (i == 31));
    end
    check("init_write_dropped", err_drop, 1'b1);

    for (int i = 0; i < 32; i++) begin
      idle(); rd_en = 1; rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      tick();
      check("swept_zero_a", rd_data_a, '0);
      check("swept_zero_b", rd_data_b, '0);
    end

    idle(); v_reg_wr_en = 1; reg_wr_addr = 7;
    reg_wr_data = {16{8'h1A}}; reg_wr_data_2 = {16{8'h2A}};
    reg_wr_data_3 = {16{8'h3A}}; reg_wr_data_4 = {16{8'h4A}};
    tick();
    idle(); rd_en = 1; rd_addr_a = 7; rd_addr_b = 8;
    tick();
    check("r7_concat", rd_data_a, {{16{8'h4A}}, {16{8'h3A}}, {16{8'h2A}}, {16{8'h1A}}});
    check("r8_zero", rd_data_b, '0);

    idle(); v_reg_wr_en = 1; reg_wr_addr = 3;
    reg_wr_data = '1; reg_wr_data_2 = '1; reg_wr_data_3 = '1; reg_wr_data_4 = '1;
    tick();
    idle(); el_wr_en = 1; reg_wr_addr = 3; reg_wr_data = 128'h12345678;
    tick();
    idle(); rd_en = 1; rd_addr_a = 3; rd_addr_b = 3;
    tick();
    check("el_merge", rd_data_a, {{480{1'b1}}, 32'h12345678});
    idle(); v_reg_wr_en = 1; el_wr_en = 1; reg_wr_addr = 3;
    reg_wr_data = '0; reg_wr_data_2 = '0; reg_wr_data_3 = '0; reg_wr_data_4 = '0;
    rd_en = 1; rd_addr_a = 3; rd_addr_b = 3;
    tick();
    check("full_beats_el", rd_data_a, '0);

    idle(); v_reg_wr_en = 1; reg_wr_addr = 9;
    reg_wr_data = {16{8'h55}}; reg_wr_data_2 = {16{8'h55}};
    reg_wr_data_3 = {16{8'h55}}; reg_wr_data_4 = {16{8'h55}};
    rd_en = 1; rd_addr_a = 9; rd_addr_b = 9;
    tick();
    check("bypass_a", rd_data_a, {64{8'h55}});
    check("bypass_b", rd_data_b, {64{8'h55}});

    idle(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 32; i++) begin idle(); tick(); end
    check("clean_err", err_drop, 1'b0);

    idle(); x_reg_wr_en = 1; reg_wr_data = 128'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check("stall_valid", x_wb_valid, 1'b1);
      check("stall_data", x_wb_data, 32'hDEADBEEF);
    end
    idle(); x_reg_wr_en = 1; reg_wr_data = 128'h1;
    tick();
    check("drop_err", err_drop, 1'b1);
    check("drop_keeps_data", x_wb_data, 32'hDEADBEEF);
    idle(); x_wb_ready = 1;
    tick();
    check("transfer_clears", x_wb_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); x_wb_ready = 1; x_reg_wr_en = 1; reg_wr_data = 128'(100 + i);
      tick();
      check("b2b_valid", x_wb_valid, 1'b1);
      check("b2b_data", x_wb_data, 32'(100 + i));
    end
    idle(); x_wb_ready = 1; tick();

    idle(); v_reg_wr_en = 1; x_reg_wr_en = 1; reg_wr_addr = 5;
    reg_wr_data = 128'hCAFE; reg_wr_data_2 = '1;
    tick();
    check("pre_rst_valid", x_wb_valid, 1'b1);
    idle(); rst = 1; tick(); rst = 0;
    check("rst_valid", x_wb_valid, 1'b0);
    check("rst_err", err_drop, 1'b0);
    for (int i = 0; i < 32; i++) begin idle(); tick(); end
    check("rerun_done", init_done, 1'b1);
    idle(); rd_en = 1; rd_addr_a = 5; rd_addr_b = 5;
    tick();
    check("r5_cleared", rd_data_a, '0);

    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      v_reg_wr_en   = ($urandom_range(0, 3) == 0);
      el_wr_en      = ($urandom_range(0, 3) == 0);
      x_reg_wr_en   = ($urandom_range(0, 2) == 0);
      reg_wr_addr   = 5'($urandom_range(0, 7));
      reg_wr_data   = {$urandom, $urandom, $urandom, $urandom};
      reg_wr_data_2 = {$urandom, $urandom, $urandom, $urandom};
      reg_wr_data_3 = {$urandom, $urandom, $urandom, $urandom};
      reg_wr_data_4 = {$urandom, $urandom, $urandom, $urandom};
      rd_en         = ($urandom_range(0, 3) != 0);
      rd_addr_a     = 5'($urandom_range(0, 7));
      rd_addr_b     = 5'($urandom_range(0, 7));
      x_wb_ready    = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
